// File: rtl/uart_dec_line_reader.sv
// Line reader: collects decimal keystrokes from the UART receiver, echoes
// them (with backspace editing) through a 4-entry echo FIFO, and on Enter
// converts the buffered digits into a saturated binary number.
module uart_dec_line_reader #(
    parameter int MAX_DIGITS = 5,
    parameter int WIDTH      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             rx_valid_i,
    input  logic [7:0]       rx_byte_i,
    output logic             echo_valid_o,
    output logic [7:0]       echo_byte_o,
    input  logic             echo_ready_i,
    output logic [WIDTH-1:0] num_o,
    output logic             num_valid_o,
    output logic             overflow_o,
    output logic             busy_o
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int BW = MAX_DIGITS * 4;
    localparam int AW = WIDTH + 4;
    localparam logic [AW-1:0] SAT = {4'b0000, {WIDTH{1'b1}}};

    typedef enum logic [1:0] {IDLE, ACTIVE, CONV, DONE} state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    rem_q, rem_d;      // digits still to be converted
    logic [AW-1:0]    acc_q, acc_d;
    logic             ovf_q, ovf_d;      // sticky saturation flag during CONV
    logic [WIDTH-1:0] num_q, num_d;
    logic             novf_q, novf_d;

    logic [3:0][7:0]  mem_q;
    logic [1:0]       rd_q;
    logic [2:0]       occ_q;
    logic [1:0]       push_n;
    logic [2:0][7:0]  push_b;
    logic             pop;
    logic [2:0]       free;
    logic [1:0]       wptr;

    logic             is_digit, is_bs, is_cr;
    logic [3:0]       cur_digit;
    logic [AW-1:0]    acc_nxt;

    assign is_digit = (rx_byte_i >= 8'h30) && (rx_byte_i <= 8'h39);
    assign is_bs    = (rx_byte_i == 8'h08) || (rx_byte_i == 8'h7F);
    assign is_cr    = (rx_byte_i == 8'h0D);

    assign echo_valid_o = (occ_q != 3'd0);
    assign echo_byte_o  = echo_valid_o ? mem_q[rd_q] : 8'h00;
    assign pop          = echo_valid_o && echo_ready_i;
    assign free         = 3'd4 - occ_q;
    assign wptr         = rd_q + occ_q[1:0];

    assign num_o       = num_q;
    assign overflow_o  = novf_q;
    assign num_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);

    // Oldest remaining digit: the newest digit sits in the low nibble, so the
    // oldest unconsumed one is nibble rem-1.
    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (int'(rem_q) == i + 1) cur_digit = bcd_q[i*4 +: 4];
        end
        acc_nxt = acc_q * AW'(10) + {{(AW-4){1'b0}}, cur_digit};
    end

    // Next-state: byte acceptance in ACTIVE, conversion in CONV, start abort.
    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        num_d   = num_q;
        novf_d  = novf_q;
        push_n  = 2'd0;
        push_b  = '0;
        case (state_q)
            ACTIVE: begin
                if (rx_valid_i) begin
                    if (is_digit) begin
                        if (cnt_q < CW'(MAX_DIGITS) && free >= 3'd1) begin
                            bcd_d     = (bcd_q << 4) | BW'(rx_byte_i[3:0]);
                            cnt_d     = cnt_q + CW'(1);
                            push_n    = 2'd1;
                            push_b[0] = rx_byte_i;
                        end
                    end else if (is_bs) begin
                        if (cnt_q != '0 && free >= 3'd3) begin
                            bcd_d     = bcd_q >> 4;
                            cnt_d     = cnt_q - CW'(1);
                            push_n    = 2'd3;
                            push_b[0] = 8'h08;
                            push_b[1] = 8'h20;
                            push_b[2] = 8'h08;
                        end
                    end else if (is_cr) begin
                        if (free >= 3'd2) begin
                            push_n    = 2'd2;
                            push_b[0] = 8'h0D;
                            push_b[1] = 8'h0A;
                            rem_d     = cnt_q;
                            acc_d     = '0;
                            ovf_d     = 1'b0;
                            state_d   = CONV;
                        end
                    end
                end
            end
            CONV: begin
                if (rem_q != '0) begin
                    // once clamped, acc*10+d always exceeds SAT, so it stays clamped
                    if (acc_nxt > SAT) begin
                        acc_d = SAT;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = acc_nxt;
                    end
                    rem_d = rem_q - CW'(1);
                end
                if (rem_q <= CW'(1)) begin
                    state_d = DONE;
                    num_d   = acc_d[WIDTH-1:0];
                    novf_d  = ovf_d;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
        endcase
        if (start_i) begin
            state_d = ACTIVE;
            bcd_d   = '0;
            cnt_d   = '0;
            num_d   = '0;
            novf_d  = 1'b0;
            push_n  = 2'd0;
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            num_q   <= '0;
            novf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            num_q   <= num_d;
            novf_q  <= novf_d;
        end
    end

    // Echo FIFO: up to three bytes pushed and one popped per cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q <= '0;
            rd_q  <= 2'd0;
            occ_q <= 3'd0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (k < int'(push_n)) mem_q[wptr + 2'(k)] <= push_b[k];
            end
            rd_q  <= rd_q + {1'b0, pop};
            occ_q <= occ_q + {1'b0, push_n} - {2'b00, pop};
        end
    end

endmodule

// File: tb/tb_uart_dec_line_reader.sv
// Scoreboard bench: a behavioural model predicts echo bytes and conversion
// results; a negedge monitor compares whatever the DUT presents.
module tb_uart_dec_line_reader;
    localparam int MAXD = 5;
    localparam int W    = 16;
    localparam longint MAXV = (longint'(1) << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0, start = 1'b0, rx_valid = 1'b0, echo_ready = 1'b1;
    logic [7:0]   rx_byte = 8'h00;
    logic         echo_valid, num_valid, overflow, busy;
    logic [7:0]   echo_byte;
    logic [W-1:0] num;

    uart_dec_line_reader #(.MAX_DIGITS(MAXD), .WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .rx_valid_i(rx_valid),
        .rx_byte_i(rx_byte), .echo_valid_o(echo_valid), .echo_byte_o(echo_byte),
        .echo_ready_i(echo_ready), .num_o(num), .num_valid_o(num_valid),
        .overflow_o(overflow), .busy_o(busy));

    always #5 clk = ~clk;

    typedef struct { longint val; bit ovf; int due; } res_t;

    int         checks = 0, errors = 0;
    res_t       exp_num[$];
    logic [7:0] exp_echo[$];
    int         digits[$];
    int         mocc = 0;      // model echo-queue occupancy
    int         mphase = 0;    // 0 idle, 1 collecting, 2 converting, 3 result
    int         mconv = 0;
    longint     mnum = 0, pend_val = 0;
    bit         movf = 0, pend_ovf = 0;
    int         cyc = 0;
    bit         mon_en = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural effect of one clock edge given the inputs held during it.
    task automatic model_step(input bit r, input bit st, input bit rv,
                              input logic [7:0] b, input bit rdy);
        int push;
        bit pop;
        longint v;
        int n;
        if (r) begin
            mphase = 0; digits.delete(); mocc = 0; exp_echo.delete();
            exp_num.delete(); mnum = 0; movf = 0;
            return;
        end
        pop  = rdy && (mocc > 0);
        push = 0;
        if (st) begin
            digits.delete(); mnum = 0; movf = 0; exp_num.delete(); mphase = 1;
        end else begin
            case (mphase)
                1: if (rv) begin
                    if (b >= 8'h30 && b <= 8'h39) begin
                        if (digits.size() < MAXD && mocc < 4) begin
                            digits.push_back(int'(b) - 48);
                            exp_echo.push_back(b);
                            push = 1;
                        end
                    end else if (b == 8'h08 || b == 8'h7F) begin
                        if (digits.size() > 0 && 4 - mocc >= 3) begin
                            void'(digits.pop_back());
                            exp_echo.push_back(8'h08);
                            exp_echo.push_back(8'h20);
                            exp_echo.push_back(8'h08);
                            push = 3;
                        end
                    end else if (b == 8'h0D) begin
                        if (4 - mocc >= 2) begin
                            exp_echo.push_back(8'h0D);
                            exp_echo.push_back(8'h0A);
                            push = 2;
                            v = 0;
                            foreach (digits[i]) v = v * 10 + digits[i];
                            pend_ovf = (v > MAXV);
                            pend_val = pend_ovf ? MAXV : v;
                            n = digits.size();
                            mconv = (n > 0) ? n : 1;
                            exp_num.push_back('{val: pend_val, ovf: pend_ovf, due: cyc + mconv});
                            mphase = 2;
                        end
                    end
                end
                2: begin
                    mconv--;
                    if (mconv == 0) begin
                        mphase = 3; mnum = pend_val; movf = pend_ovf;
                    end
                end
                3: mphase = 0;
                default: ;
            endcase
        end
        mocc = mocc - int'(pop) + push;
    endtask

    task automatic tick(input bit r, input bit st, input bit rv,
                        input logic [7:0] b, input bit rdy);
        rst = r; start = st; rx_valid = rv; rx_byte = b; echo_ready = rdy;
        @(posedge clk);
        cyc++;
        model_step(r, st, rv, b, rdy);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 8'h00, rdy);
    endtask

    task automatic send(input logic [7:0] b, input bit rdy);
        tick(0, 0, 1, b, rdy);
    endtask

    task automatic send_gap(input logic [7:0] b);
        send(b, 1);
        idle(3, 1);
    endtask

    task automatic go();
        tick(0, 1, 0, 8'h00, 1);
    endtask

    // Monitor: compare everything the DUT presents against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("echo_valid", longint'(echo_valid), longint'(mocc > 0));
            chk("busy", longint'(busy), longint'(mphase != 0));
            chk("num", longint'(num), mnum);
            chk("overflow", longint'(overflow), longint'(movf));
            chk("num_valid", longint'(num_valid), longint'(mphase == 3));
            if (echo_valid && echo_ready) begin
                if (exp_echo.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL echo_unexpected: got %0h expected none", echo_byte);
                end else begin
                    chk("echo_byte", longint'(echo_byte), longint'(exp_echo.pop_front()));
                end
            end
            if (num_valid && exp_num.size() > 0) begin
                res_t r;
                r = exp_num.pop_front();
                chk("result_num", longint'(num), r.val);
                chk("result_ovf", longint'(overflow), longint'(r.ovf));
                chk("result_cycle", longint'(cyc), longint'(r.due));
            end
        end
    end

    initial begin
        logic [7:0] b;
        int k;
        tick(1, 0, 0, 8'h00, 1);
        mon_en = 1;
        chk("reset_echo_byte", longint'(echo_byte), 0);
        idle(2, 1);

        // 123
        go(); send_gap(8'h31); send_gap(8'h32); send_gap(8'h33); send_gap(8'h0D); idle(6, 1);
        // 45<BS>6 -> 46
        go(); send_gap(8'h34); send_gap(8'h35); send_gap(8'h08); send_gap(8'h36);
        send_gap(8'h0D); idle(6, 1);
        // six 9s, only five kept -> saturate
        go(); for (int i = 0; i < 6; i++) send_gap(8'h39); send_gap(8'h0D); idle(8, 1);
        // 65535 -> exact max, no overflow
        go(); send_gap(8'h36); send_gap(8'h35); send_gap(8'h35); send_gap(8'h33);
        send_gap(8'h35); send_gap(8'h0D); idle(8, 1);
        // empty line, backspace on empty, ignored bytes
        go(); send_gap(8'h0D); idle(4, 1);
        go(); send_gap(8'h08); send_gap(8'h7F); send_gap(8'h61); send_gap(8'h20);
        send_gap(8'h0D); idle(4, 1);
        // full echo queue drops a backspace; digit still fits
        go(); send(8'h31, 0); send(8'h32, 0); send(8'h33, 0); send(8'h08, 0);
        send(8'h37, 0); idle(3, 0); idle(5, 1); send_gap(8'h0D); idle(8, 1);
        // start aborts conversion
        go(); for (int i = 0; i < 5; i++) send_gap(8'h31 + 8'(i));
        send(8'h0D, 1); idle(2, 1); go(); idle(8, 1);
        // reset mid-line
        go(); send_gap(8'h31); send(8'h32, 1); tick(1, 0, 0, 8'h00, 1);
        chk("rst_echo_byte", longint'(echo_byte), 0);
        idle(4, 1);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            bit r, st, rv, rdy;
            r   = ($urandom_range(0, 399) == 0);
            st  = (mphase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 149) == 0);
            rv  = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            k   = $urandom_range(0, 19);
            if (k < 12)       b = 8'h30 + 8'($urandom_range(0, 9));
            else if (k < 14)  b = 8'h08;
            else if (k == 14) b = 8'h7F;
            else if (k < 17)  b = 8'h0D;
            else if (k == 17) b = 8'h61;
            else if (k == 18) b = 8'h20;
            else              b = 8'($urandom_range(0, 255));
            tick(r, st, rv, b, rdy);
        end

        idle(20, 1);
        chk("echo_drained", longint'(exp_echo.size()), 0);
        chk("results_drained", longint'(exp_num.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_dec_line_reader.md
# uart_dec_line_reader

Line-input stage that sits between the UART receiver and the arithmetic/compute stage of the lab designs. It accepts received bytes while armed and echoes accepted keystrokes through a small echo queue to the UART transmitter. It supports backspace editing, and on Enter converts the buffered decimal digits into a saturated binary number with a one-cycle valid pulse. The top-level FSM arms it once per operand and waits for `num_valid` before prompting for the next operand.

## Interface
- `MAX_DIGITS`, default 5: maximum number of decimal digits buffered (1–8).
- `WIDTH`, default 16: width of the binary result.
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `start` in 1: one-cycle pulse that clears the digit buffer and arms the reader.
- `rx_valid` in 1: one-cycle strobe from the UART (`received`).
- `rx_byte` in 8: received byte; qualified by `rx_valid`.
- `echo_valid` out 1: echo queue not empty.
- `echo_byte` out 8: head of the echo queue.
- `echo_ready` in 1: transmitter accepts `echo_byte`.
- `num` out WIDTH: converted value; held until the next `start` or `rst`.
- `num_valid` out 1: one-cycle pulse when `num` is updated.
- `overflow` out 1: value exceeded 2^WIDTH−1 and `num` saturated; held with `num`.
- `busy` out 1: high when the state is not IDLE.

## Operation
- States:
  - IDLE: `start` → ACTIVE.
  - ACTIVE: Enter → CONV.
  - CONV: last digit processed → DONE.
  - DONE: → IDLE unconditionally after one cycle.
- `rst` has priority over everything. `start` in any state clears the digit buffer, digit count, `num` and `overflow`, and goes to ACTIVE; this includes aborting CONV or DONE. `start` does not flush the echo queue.
- Digit storage is a BCD shift register of MAX_DIGITS nibbles plus a digit count `cnt` (0..MAX_DIGITS).
- `rx_byte` handling in ACTIVE only; `rx_valid` is ignored in every other state:
  - '0'..'9' (0x30–0x39) with cnt<MAX_DIGITS: append the nibble, cnt+1, enqueue echo of the digit.
  - Digit with cnt=MAX_DIGITS: ignored, no echo.
  - 0x08 or 0x7F with cnt>0: drop the newest digit, cnt−1, enqueue 0x08,0x20,0x08.
  - 0x08 or 0x7F with cnt=0: ignored, no echo.
  - 0x0D: enqueue 0x0D,0x0A and go to CONV. This applies even when cnt=0.
  - Any other byte: ignored, no echo.
- If the echo queue lacks free space for the whole echo sequence of a byte, that byte is ignored entirely: no buffer or state change, nothing enqueued.
- Echo queue:
  - 4-entry FIFO.
  - Pop when `echo_valid && echo_ready`.
  - A pop and a push in the same cycle are both honoured.
  - Multi-byte sequences are pushed in the same cycle.
- CONV:
  - Accumulator `acc` is WIDTH+4 bits, cleared on entry.
  - Each cycle consumes the oldest remaining digit: acc = acc*10 + d, one digit per cycle.
  - When acc > 2^WIDTH−1, acc is clamped to 2^WIDTH−1 and a sticky overflow flag is set; later digits keep acc clamped.
  - With cnt=0, CONV lasts one cycle with acc=0.
- DONE: `num` ← acc[WIDTH−1:0], `overflow` ← sticky flag, `num_valid`=1.

## Timing
- Reset values:
  - state IDLE
  - `busy`=0, `num`=0, `num_valid`=0, `overflow`=0
  - echo queue empty, `echo_valid`=0, `echo_byte`=0x00
  - cnt=0
- `start` in cycle t → ACTIVE and `busy`=1 from t+1. A byte is accepted in ACTIVE when `rx_valid` is sampled on a clock edge where the state is ACTIVE.
- An accepted byte at edge t gives `echo_valid`=1 and the head byte at t+1 when the queue was empty. `echo_byte` is stable while `echo_valid` is high and not popped.
- Enter at edge t: CONV during cycles t+1 .. t+max(cnt,1), DONE in cycle t+max(cnt,1)+1, where `num_valid`=1 and `num` is valid. IDLE and `busy`=0 in the following cycle.
- `rx_valid` arriving in the same cycle as `start` is ignored.
- `num` and `overflow` change only in DONE, on `start`, or on `rst`.

## Test plan
- Reset, `start`, bytes "1","2","3",0x0D → echo stream 31 32 33 0D 0A; `num_valid` pulse exactly 4 cycles after the CR edge; `num`=123, `overflow`=0.
- Bytes "4","5",0x08,"6",0x0D → echo 34 35 08 20 08 36 0D 0A; `num`=46.
- `MAX_DIGITS`=5, bytes "9" ×6 then 0x0D → only five echoes of 0x39; `num`=0xFFFF, `overflow`=1. A second run with "65535" gives `num`=0xFFFF, `overflow`=0.
- 0x0D with no digits, and 0x08 with no digits → backspace produces no echo; `num`=0 after 2 cycles; 'a' and 0x20 are never echoed.
- Hold `echo_ready`=0 with the queue filled to 3 entries, then send 0x08 with cnt>0 → byte dropped, cnt unchanged. Then send "7" → accepted and echoed after draining.
- `start` asserted mid-CONV (cnt=5) → no `num_valid`, `num`=0, state ACTIVE. A `rst` pulse mid-ACTIVE → all outputs return to their reset values on the next cycle.
